// File: rtl/gray_ptr_gen.sv
// Up/down binary pointer with a separately registered Gray copy for clock-domain crossing.
// gray is its own flop so the crossing bus never carries combinational glitches.
module gray_ptr_gen #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_bin,
    output logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] gray_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] BIN_ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] BIN_MAX = '1;

    logic [WIDTH-1:0] bin_n;
    logic [WIDTH-1:0] gray_n;
    logic             wrap_n;

    // Load wins over stepping and never reports a wrap.
    always_comb begin
        bin_n  = bin;
        wrap_n = 1'b0;
        if (load) begin
            bin_n = load_bin;
        end else if (en) begin
            if (up) begin
                bin_n  = bin + BIN_ONE;
                wrap_n = (bin == BIN_MAX);
            end else begin
                bin_n  = bin - BIN_ONE;
                wrap_n = (bin == '0);
            end
        end
    end

    always_comb begin
        gray_n = bin_n ^ (bin_n >> 1);
    end

    assign gray_next = gray_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin  <= '0;
            gray <= '0;
            wrap <= 1'b0;
        end else begin
            bin  <= bin_n;
            gray <= gray_n;
            wrap <= wrap_n;
        end
    end

endmodule

// File: tb/tb_gray_ptr_gen.sv
// Self-checking bench for gray_ptr_gen (WIDTH=4): directed scenarios plus a long random
// sequence compared against a plain arithmetic pointer model and a Gray decoder.
module tb_gray_ptr_gen;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic         up;
    logic         load;
    logic [W-1:0] load_bin;
    logic [W-1:0] bin;
    logic [W-1:0] gray;
    logic [W-1:0] gray_next;
    logic         wrap;

    int errors = 0;
    int checks = 0;

    // Reference model: the pointer as a plain modular number.
    logic [W-1:0] m_bin  = '0;
    logic         m_wrap = 1'b0;

    gray_ptr_gen #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .up        (up),
        .load      (load),
        .load_bin  (load_bin),
        .bin       (bin),
        .gray      (gray),
        .gray_next (gray_next),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] enc(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Far-side decoder: each binary bit is the XOR of all Gray bits at or above it.
    function automatic logic [W-1:0] dec(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Drive one cycle from a negedge; checks gray_next before the edge and advances the model.
    task automatic cycle(input logic l, input logic [W-1:0] lb, input logic e, input logic u);
        logic [W-1:0] nb;
        logic         nw;
        load = l; load_bin = lb; en = e; up = u;
        nw = 1'b0;
        if (l) nb = lb;
        else if (e && u) begin nb = m_bin + 4'd1; nw = (m_bin == 4'd15); end
        else if (e) begin nb = m_bin - 4'd1; nw = (m_bin == 4'd0); end
        else nb = m_bin;
        #1;
        checks++;
        if (gray_next !== enc(nb)) begin
            errors++;
            $display("FAIL gray_next: got %b expected %b", gray_next, enc(nb));
        end
        @(posedge clk);
        @(negedge clk);
        m_bin  = nb;
        m_wrap = nw;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1 rst_n = 1'b0;
        load = 1'b0; en = 1'b0; up = 1'b0; load_bin = '0;
        #1 rst_n = 1'b1;
        m_bin = '0; m_wrap = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_bin = '0;
        #3;
        checks++;
        if (bin !== '0 || gray !== '0 || wrap !== 1'b0 || gray_next !== '0) begin
            errors++;
            $display("FAIL reset: bin=%b gray=%b wrap=%b gray_next=%b expected all 0", bin, gray, wrap, gray_next);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_count_up();
        logic [W-1:0] seq [17];
        logic [W-1:0] prev;
        seq = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000, 4'b0000};
        do_reset();
        prev = gray;
        for (int i = 1; i <= 16; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b1);
            checks++;
            if (gray !== seq[i] || wrap !== (i == 16) || bin !== m_bin) begin
                errors++;
                $display("FAIL count_up step %0d: gray=%b wrap=%b bin=%b expected gray=%b wrap=%b bin=%b",
                         i, gray, wrap, bin, seq[i], (i == 16), m_bin);
            end
            checks++;
            if ($countones(gray ^ prev) != 1) begin
                errors++;
                $display("FAIL count_up one_bit step %0d: %b -> %b", i, prev, gray);
            end
            checks++;
            if (dec(gray) !== bin) begin
                errors++;
                $display("FAIL count_up decode step %0d: dec(gray)=%b bin=%b", i, dec(gray), bin);
            end
            prev = gray;
        end
    endtask

    task automatic test_count_down();
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bin !== 4'b1111 || gray !== 4'b1000 || wrap !== 1'b1) begin
            errors++;
            $display("FAIL down_first: bin=%b gray=%b wrap=%b expected 1111 1000 1", bin, gray, wrap);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (bin !== 4'b1110 || gray !== 4'b1001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL down_second: bin=%b gray=%b wrap=%b expected 1110 1001 0", bin, gray, wrap);
        end
    endtask

    task automatic test_load();
        cycle(1'b1, 4'b1011, 1'b0, 1'b0);
        checks++;
        if (bin !== 4'b1011 || gray !== 4'b1110 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load: bin=%b gray=%b wrap=%b expected 1011 1110 0", bin, gray, wrap);
        end
        cycle(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (bin !== 4'b1100 || gray !== 4'b1010 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_then_up: bin=%b gray=%b wrap=%b expected 1100 1010 0", bin, gray, wrap);
        end
    endtask

    task automatic test_priority_hold();
        cycle(1'b1, 4'b1111, 1'b0, 1'b0);
        cycle(1'b1, 4'b0000, 1'b1, 1'b1);
        checks++;
        if (bin !== 4'b0000 || gray !== 4'b0000 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL load_priority: bin=%b gray=%b wrap=%b expected 0000 0000 0", bin, gray, wrap);
        end
        cycle(1'b1, 4'b0110, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 4'($urandom_range(0, 15)), 1'b0, 1'($urandom_range(0, 1)));
            checks++;
            if (bin !== 4'b0110 || gray !== 4'b0101 || wrap !== 1'b0) begin
                errors++;
                $display("FAIL hold %0d: bin=%b gray=%b wrap=%b expected 0110 0101 0", i, bin, gray, wrap);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (bin !== 4'b0110) begin
            errors++;
            $display("FAIL pre_reset_bin: got %b expected 0110", bin);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bin !== '0 || gray !== '0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: bin=%b gray=%b wrap=%b expected all 0", bin, gray, wrap);
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (bin !== '0 || gray !== '0 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: bin=%b gray=%b wrap=%b expected all 0", bin, gray, wrap);
        end
        rst_n = 1'b1;
        m_bin = '0; m_wrap = 1'b0;
        cycle(1'b0, '0, 1'b1, 1'b1);
        checks++;
        if (bin !== 4'b0001 || gray !== 4'b0001 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL after_release: bin=%b gray=%b wrap=%b expected 0001 0001 0", bin, gray, wrap);
        end
    endtask

    task automatic test_random_round_trip();
        logic [W-1:0] prev;
        logic         l;
        logic         e;
        for (int i = 0; i < 10000; i++) begin
            prev = gray;
            l = ($urandom_range(0, 15) == 0);
            e = ($urandom_range(0, 3) != 0);
            cycle(l, 4'($urandom_range(0, 15)), e, 1'($urandom_range(0, 1)));
            checks++;
            if (bin !== m_bin || gray !== enc(m_bin) || wrap !== m_wrap) begin
                errors++;
                $display("FAIL random %0d: bin=%b gray=%b wrap=%b expected %b %b %b",
                         i, bin, gray, wrap, m_bin, enc(m_bin), m_wrap);
            end
            checks++;
            if (dec(gray) !== bin) begin
                errors++;
                $display("FAIL round_trip %0d: dec(gray)=%b bin=%b", i, dec(gray), bin);
            end
            if (!l && e) begin
                checks++;
                if ($countones(gray ^ prev) != 1) begin
                    errors++;
                    $display("FAIL random_one_bit %0d: %b -> %b", i, prev, gray);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_count_up();
        test_count_down();
        test_load();
        test_priority_hold();
        test_async_reset();
        test_random_round_trip();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gray_ptr_gen.md
# gray_ptr_gen

Registered binary-to-Gray pointer generator: an up/down binary counter whose value is re-encoded to Gray code every cycle and presented on registered outputs. It is the encoder-side counterpart of the team's Gray-to-binary decoder. It produces the Gray-coded pointers that cross clock domains, for example async FIFO read/write pointers. The far-side decoder turns them back into binary.

## Interface
- WIDTH, 4, pointer width in bits; legal range 2..16.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  step the counter by one this cycle.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled only when en=1.
- load  input  1  synchronous load of load_bin; takes priority over en.
- load_bin  input  WIDTH  binary value to load.
- bin  output  WIDTH  registered binary pointer.
- gray  output  WIDTH  registered Gray encoding of bin.
- gray_next  output  WIDTH  combinational Gray encoding of the value bin will take at the next edge.
- wrap  output  1  registered one-cycle pulse, high in the cycle after a step that crossed the modulus boundary.

## Operation
- Next-value selection, evaluated each rising edge:
  - load=1: bin_n = load_bin.
  - else en=1, up=1: bin_n = bin + 1 mod 2^WIDTH.
  - else en=1, up=0: bin_n = bin - 1 mod 2^WIDTH.
  - else: bin_n = bin (hold).
- Encoding: gray_n = bin_n ^ (bin_n >> 1), i.e. gray[WIDTH-1] = bin[WIDTH-1] and gray[i] = bin[i+1] ^ bin[i].
- Registers: bin <= bin_n and gray <= gray_n, both on the same edge. gray is a flop output and is never combinationally derived from bin, so it is CDC-safe.
- gray_next = gray_n; it is exposed for full/empty comparison logic in the local domain.
- Wrap condition (wrap_n):
  - en=1, up=1, bin=2^WIDTH-1, load=0; or
  - en=1, up=0, bin=0, load=0.
  - wrap <= wrap_n. Otherwise wrap is 0.
- Loads never assert wrap, including a load of 0 while bin=max.
- Single-bit-change invariant: on any en step without load, gray differs from its previous value in exactly one bit, including at wrap. On a load, any number of bits may change. Load is permitted only while the remote domain is quiesced.
- No internal state beyond bin, gray and wrap. The gray register exists in addition to bin and is not derived from it.

## Timing
- Reset (rst_n low, asynchronous assertion): bin=0, gray=0, wrap=0 immediately, without waiting for clk. gray_next then reads 0 while en=0 and load=0.
- Reset release is taken synchronously by the design; the first state change occurs at the first rising edge with rst_n high.
- Reset asserted mid-count: the count is lost, all outputs go to 0, and no wrap pulse is generated.
- Latency: 1 cycle from en/load sampled to bin/gray/wrap updated. gray_next has 0-cycle combinational latency.
- Simultaneous load and en: load wins, en and up are ignored, wrap=0.
- en held high: one step per cycle, with continuous wrap-around and one wrap pulse per crossing.
- up toggling while en=0 has no effect.

## Test plan
- Count up, WIDTH=4, en=1, up=1 from reset:
  - gray follows 0000, 0001, 0011, 0010, 0110, 0111, 0101, 0100, 1100, 1101, 1111, 1110, 1010, 1011, 1001, 1000, then 0000.
  - wrap=1 only in the cycle gray returns to 0000.
  - A scoreboard checks exactly one bit changes per step.
- Count down from reset, en=1, up=0:
  - First edge: bin=1111, gray=1000, wrap=1.
  - Next edge: bin=1110, gray=1001, wrap=0.
- Load: load=1, load_bin=1011.
  - Next edge: bin=1011, gray=1110, wrap=0.
  - Then en=1, up=1: bin=1100, gray=1010.
- Priority and hold:
  - bin=1111, load=1, load_bin=0000, en=1, up=1: bin=0000, wrap=0.
  - en=0 for 5 cycles: bin and gray unchanged.
  - gray_next equals the following cycle's gray in every cycle.
- Async reset mid-count:
  - Drop rst_n between edges at bin=0110. bin, gray and wrap go to 0 before the next edge.
  - Release with en=1, up=1: first edge gives bin=0001, gray=0001.
- Round trip: drive gray through the team's Gray-to-binary decoder. The decoded value equals bin for all 16 values and for random en/up/load sequences over 10k cycles.
